// File: rtl/lagd_mem_bank_arbiter.sv
// lagd_mem_bank_arbiter
// Shares one single-port SRAM bank between a narrow and a wide class of
// TCDM-style requesters. The narrow class normally wins. A wide requester
// that has stalled long enough takes priority. Within each class the
// requesters are served round-robin. A fixed-latency response pipe returns
// each read to the requester that issued it.
// Optional feature: define LAGD_MEM_ARB_PERF_CNT_EN to add a 32-bit counter
// of cycles with two or more active requests. The counter adds the ports
// perf_clr_i and perf_conflict_o.
module lagd_mem_bank_arbiter #(
    parameter int unsigned NumNarrowReq      = 2,
    parameter int unsigned NumWideReq        = 1,
    parameter int unsigned AddrWidth         = 11,
    parameter int unsigned DataWidth         = 64,
    parameter int unsigned BankAccessLatency = 1,
    parameter int unsigned WidePriorityWait  = 4,
    parameter int unsigned NwPorts           = (NumWideReq > 0) ? NumWideReq : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NumNarrowReq-1:0]              n_req_i,
    input  logic [NumNarrowReq-1:0]              n_we_i,
    input  logic [NumNarrowReq*AddrWidth-1:0]    n_addr_i,
    input  logic [NumNarrowReq*DataWidth-1:0]    n_wdata_i,
    input  logic [NumNarrowReq*DataWidth/8-1:0]  n_be_i,
    output logic [NumNarrowReq-1:0]              n_gnt_o,
    output logic [NumNarrowReq-1:0]              n_rvalid_o,
    output logic [DataWidth-1:0]                 n_rdata_o,
    input  logic [NwPorts-1:0]                   w_req_i,
    input  logic [NwPorts-1:0]                   w_we_i,
    input  logic [NwPorts*AddrWidth-1:0]         w_addr_i,
    input  logic [NwPorts*DataWidth-1:0]         w_wdata_i,
    input  logic [NwPorts*DataWidth/8-1:0]       w_be_i,
    output logic [NwPorts-1:0]                   w_gnt_o,
    output logic [NwPorts-1:0]                   w_rvalid_o,
    output logic [DataWidth-1:0]                 w_rdata_o,
    output logic                                 bank_req_o,
    output logic                                 bank_we_o,
    output logic [AddrWidth-1:0]                 bank_addr_o,
    output logic [DataWidth-1:0]                 bank_wdata_o,
    output logic [DataWidth/8-1:0]               bank_be_o,
    input  logic [DataWidth-1:0]                 bank_rdata_i
`ifdef LAGD_MEM_ARB_PERF_CNT_EN
    ,
    input  logic                                 perf_clr_i,
    output logic [31:0]                          perf_conflict_o
`endif
);

    localparam int unsigned BeW    = DataWidth / 8;
    localparam int unsigned NIdxW  = (NumNarrowReq > 1) ? $clog2(NumNarrowReq) : 1;
    localparam int unsigned WIdxW  = (NwPorts > 1) ? $clog2(NwPorts) : 1;
    localparam int unsigned IdxW   = (NIdxW > WIdxW) ? NIdxW : WIdxW;
    localparam int unsigned CntW   = (WidePriorityWait > 0) ? $clog2(WidePriorityWait + 1) : 1;
    localparam bit          HasWide = (NumWideReq > 0);
    localparam bit          WaitEn  = (WidePriorityWait != 0);
    localparam logic [CntW-1:0]  WaitThr = CntW'(WidePriorityWait);
    localparam logic [NIdxW-1:0] NLast   = NIdxW'(NumNarrowReq - 1);
    localparam logic [WIdxW-1:0] WLast   = WIdxW'(NwPorts - 1);

    logic [NIdxW-1:0]   r_narrowPtr;
    logic [WIdxW-1:0]   r_widePtr;
    logic [CntW-1:0]    r_waitCnt;
    logic [BankAccessLatency-1:0] r_pipeValid;
    logic [BankAccessLatency-1:0] r_pipeWide;
    logic [IdxW-1:0]    r_pipeIdx [BankAccessLatency];

    logic [NwPorts-1:0] w_wReq;
    logic               w_anyN;
    logic               w_anyW;
    logic               w_nFound;
    logic               w_wFound;
    logic [NIdxW-1:0]   w_nWinner;
    logic [WIdxW-1:0]   w_wWinner;
    logic               w_wideWins;
    logic               w_narrowWins;
    logic               w_grantRead;
    logic [IdxW-1:0]    w_grantIdx;
    logic               w_outValid;
    logic               w_outWide;
    logic [IdxW-1:0]    w_outIdx;

    assign w_wReq       = HasWide ? w_req_i : '0;
    assign w_anyN       = |n_req_i;
    assign w_anyW       = |w_wReq;
    assign w_wideWins   = w_anyW && (!w_anyN || (WaitEn && (r_waitCnt >= WaitThr)));
    assign w_narrowWins = w_anyN && !w_wideWins;
    assign w_grantRead  = (w_narrowWins || w_wideWins) && !bank_we_o;
    assign w_grantIdx   = w_narrowWins ? IdxW'(w_nWinner) : IdxW'(w_wWinner);
    assign w_outValid   = r_pipeValid[BankAccessLatency-1];
    assign w_outWide    = r_pipeWide[BankAccessLatency-1];
    assign w_outIdx     = r_pipeIdx[BankAccessLatency-1];

    // Narrow round-robin search: first requester at or after the pointer wins
    always_comb begin
        w_nFound  = 1'b0;
        w_nWinner = '0;
        for (int i = 0; i < int'(NumNarrowReq); i++) begin
            int idx;
            idx = int'(r_narrowPtr) + i;
            if (idx >= int'(NumNarrowReq)) idx = idx - int'(NumNarrowReq);
            if (!w_nFound && n_req_i[idx[NIdxW-1:0]]) begin
                w_nFound  = 1'b1;
                w_nWinner = idx[NIdxW-1:0];
            end
        end
    end

    // Wide round-robin search, same scheme as the narrow class
    always_comb begin
        w_wFound  = 1'b0;
        w_wWinner = '0;
        for (int i = 0; i < int'(NwPorts); i++) begin
            int idx;
            idx = int'(r_widePtr) + i;
            if (idx >= int'(NwPorts)) idx = idx - int'(NwPorts);
            if (!w_wFound && w_wReq[idx[WIdxW-1:0]]) begin
                w_wFound  = 1'b1;
                w_wWinner = idx[WIdxW-1:0];
            end
        end
    end

    // Grant the winning requester and route its request onto the bank
    always_comb begin
        n_gnt_o      = '0;
        w_gnt_o      = '0;
        bank_req_o   = 1'b0;
        bank_we_o    = 1'b0;
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        bank_be_o    = '0;
        if (w_narrowWins) begin
            n_gnt_o[w_nWinner] = 1'b1;
            bank_req_o   = 1'b1;
            bank_we_o    = n_we_i[w_nWinner];
            bank_addr_o  = n_addr_i[w_nWinner*AddrWidth +: AddrWidth];
            bank_wdata_o = n_wdata_i[w_nWinner*DataWidth +: DataWidth];
            bank_be_o    = n_be_i[w_nWinner*BeW +: BeW];
        end else if (w_wideWins) begin
            w_gnt_o[w_wWinner] = 1'b1;
            bank_req_o   = 1'b1;
            bank_we_o    = w_we_i[w_wWinner];
            bank_addr_o  = w_addr_i[w_wWinner*AddrWidth +: AddrWidth];
            bank_wdata_o = w_wdata_i[w_wWinner*DataWidth +: DataWidth];
            bank_be_o    = w_be_i[w_wWinner*BeW +: BeW];
        end
    end

    // Advance the pointer of the granted class past its winner
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_narrowPtr <= '0;
            r_widePtr   <= '0;
        end else if (w_narrowWins) begin
            r_narrowPtr <= (w_nWinner == NLast) ? '0 : w_nWinner + 1'b1;
        end else if (w_wideWins) begin
            r_widePtr   <= (w_wWinner == WLast) ? '0 : w_wWinner + 1'b1;
        end
    end

    // Count consecutive cycles a waiting wide request loses to narrow
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_waitCnt <= '0;
        end else if (!w_anyW || w_wideWins) begin
            r_waitCnt <= '0;
        end else if (w_narrowWins && (r_waitCnt != WaitThr)) begin
            r_waitCnt <= r_waitCnt + 1'b1;
        end
    end

    // Shift read tags down the pipe so responses match the bank latency
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pipeValid <= '0;
            r_pipeWide  <= '0;
            for (int s = 0; s < int'(BankAccessLatency); s++) r_pipeIdx[s] <= '0;
        end else begin
            r_pipeValid[0] <= w_grantRead;
            r_pipeWide[0]  <= w_wideWins;
            r_pipeIdx[0]   <= w_grantIdx;
            for (int s = 1; s < int'(BankAccessLatency); s++) begin
                r_pipeValid[s] <= r_pipeValid[s-1];
                r_pipeWide[s]  <= r_pipeWide[s-1];
                r_pipeIdx[s]   <= r_pipeIdx[s-1];
            end
        end
    end

    // Steer the bank read data back to the class and requester that asked
    always_comb begin
        n_rvalid_o = '0;
        w_rvalid_o = '0;
        n_rdata_o  = '0;
        w_rdata_o  = '0;
        if (w_outValid) begin
            if (w_outWide) begin
                w_rvalid_o[w_outIdx[WIdxW-1:0]] = 1'b1;
                w_rdata_o = bank_rdata_i;
            end else begin
                n_rvalid_o[w_outIdx[NIdxW-1:0]] = 1'b1;
                n_rdata_o = bank_rdata_i;
            end
        end
    end

`ifdef LAGD_MEM_ARB_PERF_CNT_EN
    logic [31:0] r_perfCnt;
    logic        w_conflict;

    // Flag cycles where two or more requesters compete for the bank
    always_comb begin
        int active;
        active = 0;
        for (int i = 0; i < int'(NumNarrowReq); i++) active = active + int'(n_req_i[i]);
        for (int i = 0; i < int'(NwPorts); i++) active = active + int'(w_wReq[i]);
        w_conflict = (active >= 2);
    end

    // Wrapping conflict counter; a clear request takes precedence
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_perfCnt <= '0;
        end else if (perf_clr_i) begin
            r_perfCnt <= '0;
        end else if (w_conflict) begin
            r_perfCnt <= r_perfCnt + 32'd1;
        end
    end

    assign perf_conflict_o = r_perfCnt;
`endif

endmodule

// File: tb/tb_lagd_mem_bank_arbiter.sv
// tb_lagd_mem_bank_arbiter
// Directed bench for lagd_mem_bank_arbiter. Instance dutA uses the default
// parameters (latency 1, wide wait 4). Instance dutB uses latency 3 and
// wide wait 0. Both instances share the request inputs, and each instance
// gets its own bank read data.
module tb_lagd_mem_bank_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  nReq, nWe;
   logic [21:0] nAddr;
   logic [127:0] nWdata;
   logic [15:0] nBe;
   logic [0:0]  wReq, wWe;
   logic [10:0] wAddr;
   logic [63:0] wWdata;
   logic [7:0]  wBe;
   logic [63:0] rdA, rdB;

   logic [1:0]  nGntA, nRvalA, nGntB, nRvalB;
   logic [63:0] nRdataA, wRdataA, nRdataB, wRdataB;
   logic [0:0]  wGntA, wRvalA, wGntB, wRvalB;
   logic        bankReqA, bankWeA, bankReqB, bankWeB;
   logic [10:0] bankAddrA, bankAddrB;
   logic [63:0] bankWdataA, bankWdataB;
   logic [7:0]  bankBeA, bankBeB;
`ifdef LAGD_MEM_ARB_PERF_CNT_EN
   logic        perfClr;
   logic [31:0] perfA, perfB;
`endif

   int checkCount = 0;
   int passCount  = 0;

   always #5 clk = ~clk;

   lagd_mem_bank_arbiter dutA (
      .clk_i(clk), .rst_i(rst),
      .n_req_i(nReq), .n_we_i(nWe), .n_addr_i(nAddr), .n_wdata_i(nWdata), .n_be_i(nBe),
      .n_gnt_o(nGntA), .n_rvalid_o(nRvalA), .n_rdata_o(nRdataA),
      .w_req_i(wReq), .w_we_i(wWe), .w_addr_i(wAddr), .w_wdata_i(wWdata), .w_be_i(wBe),
      .w_gnt_o(wGntA), .w_rvalid_o(wRvalA), .w_rdata_o(wRdataA),
      .bank_req_o(bankReqA), .bank_we_o(bankWeA), .bank_addr_o(bankAddrA),
      .bank_wdata_o(bankWdataA), .bank_be_o(bankBeA), .bank_rdata_i(rdA)
`ifdef LAGD_MEM_ARB_PERF_CNT_EN
      , .perf_clr_i(perfClr), .perf_conflict_o(perfA)
`endif
   );

   lagd_mem_bank_arbiter #(.BankAccessLatency(3), .WidePriorityWait(0)) dutB (
      .clk_i(clk), .rst_i(rst),
      .n_req_i(nReq), .n_we_i(nWe), .n_addr_i(nAddr), .n_wdata_i(nWdata), .n_be_i(nBe),
      .n_gnt_o(nGntB), .n_rvalid_o(nRvalB), .n_rdata_o(nRdataB),
      .w_req_i(wReq), .w_we_i(wWe), .w_addr_i(wAddr), .w_wdata_i(wWdata), .w_be_i(wBe),
      .w_gnt_o(wGntB), .w_rvalid_o(wRvalB), .w_rdata_o(wRdataB),
      .bank_req_o(bankReqB), .bank_we_o(bankWeB), .bank_addr_o(bankAddrB),
      .bank_wdata_o(bankWdataB), .bank_be_o(bankBeB), .bank_rdata_i(rdB)
`ifdef LAGD_MEM_ARB_PERF_CNT_EN
      , .perf_clr_i(perfClr), .perf_conflict_o(perfB)
`endif
   );

   // Drive one cycle's worth of request inputs
   task automatic applyStimulus(input logic [1:0] nr, input logic [1:0] nw,
                                input logic [10:0] a0, input logic [10:0] a1,
                                input logic wr, input logic ww, input logic [10:0] wa);
      nReq   = nr;
      nWe    = nw;
      nAddr  = {a1, a0};
      nWdata = {64'hAAAA_0001_0000_0001, 64'hAAAA_0000_0000_0000};
      nBe    = 16'hFFFF;
      wReq   = wr;
      wWe    = ww;
      wAddr  = wa;
      wWdata = 64'hBBBB_0000_0000_0000;
      wBe    = 8'hFF;
   endtask

   // Compare one observed value against its expected value
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Move to just after the next rising edge
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Pulse reset for one cycle with idle inputs
   task automatic doReset();
      nextCycle();
      rst = 1'b1;
      applyStimulus(2'b00, 2'b00, 11'h0, 11'h0, 1'b0, 1'b0, 11'h0);
      nextCycle();
      rst = 1'b0;
   endtask

   // Directed scenario sequence
   initial begin
      rst = 1'b1;
      rdA = '0;
      rdB = '0;
`ifdef LAGD_MEM_ARB_PERF_CNT_EN
      perfClr = 1'b0;
`endif
      applyStimulus(2'b00, 2'b00, 11'h0, 11'h0, 1'b0, 1'b0, 11'h0);
      nextCycle();
      #3;
      checkOutput("rst_ngnt",   nGntA, 0);
      checkOutput("rst_bankreq", bankReqA, 0);
      checkOutput("rst_nrvalid", nRvalA, 0);
      checkOutput("rst_nrdata", nRdataA, 0);
      checkOutput("rst_wrvalidB", wRvalB, 0);
      rst = 1'b0;

      // single narrow read, latency 1
      nextCycle();
      applyStimulus(2'b01, 2'b00, 11'h010, 11'h0, 1'b0, 1'b0, 11'h0);
      #3;
      checkOutput("rd_gnt", nGntA, 64'h1);
      checkOutput("rd_bankreq", bankReqA, 1);
      checkOutput("rd_addr", bankAddrA, 64'h010);
      checkOutput("rd_we", bankWeA, 0);
      nextCycle();
      applyStimulus(2'b00, 2'b00, 11'h0, 11'h0, 1'b0, 1'b0, 11'h0);
      rdA = 64'hDEAD_BEEF_0000_0010;
      #3;
      checkOutput("rd_rvalid", nRvalA, 64'h1);
      checkOutput("rd_rdata", nRdataA, 64'hDEAD_BEEF_0000_0010);
      checkOutput("rd_idle", bankReqA, 0);

      // round-robin between two narrow writers
      doReset();
      for (int c = 0; c < 4; c++) begin
         nextCycle();
         applyStimulus(2'b11, 2'b11, 11'h001, 11'h002, 1'b0, 1'b0, 11'h0);
         #3;
         checkOutput($sformatf("rr_gnt%0d", c), nGntA, (c % 2 == 0) ? 64'h1 : 64'h2);
         checkOutput($sformatf("rr_rvalid%0d", c), nRvalA, 0);
      end
      nextCycle();
      applyStimulus(2'b00, 2'b00, 11'h0, 11'h0, 1'b0, 1'b0, 11'h0);
      #3;
      checkOutput("rr_wr_no_rvalid", nRvalA, 0);

      // wide starvation: wide wins on cycle 4 only with wait 4, never with wait 0
      doReset();
      for (int c = 0; c < 6; c++) begin
         nextCycle();
         applyStimulus(2'b01, 2'b01, 11'h001, 11'h0, 1'b1, 1'b1, 11'h100);
         #3;
         checkOutput($sformatf("st_wgntA%0d", c), wGntA, (c == 4) ? 64'h1 : 64'h0);
         checkOutput($sformatf("st_ngntA%0d", c), nGntA, (c == 4) ? 64'h0 : 64'h1);
         checkOutput($sformatf("st_wgntB%0d", c), wGntB, 0);
      end
      nextCycle();
      applyStimulus(2'b00, 2'b00, 11'h0, 11'h0, 1'b1, 1'b1, 11'h100);
      #3;
      checkOutput("st_wonly_A", wGntA, 64'h1);
      checkOutput("st_wonly_B", wGntB, 64'h1);
      checkOutput("st_waddr", bankAddrA, 64'h100);
      checkOutput("st_wwe", bankWeA, 1);

      // latency 3 reads from n0, w0, n1
      doReset();
      nextCycle();
      applyStimulus(2'b01, 2'b00, 11'h020, 11'h0, 1'b0, 1'b0, 11'h0);
      #3;
      checkOutput("l3_gnt_n0", nGntB, 64'h1);
      checkOutput("l3_addr_n0", bankAddrB, 64'h020);
      nextCycle();
      applyStimulus(2'b00, 2'b00, 11'h0, 11'h0, 1'b1, 1'b0, 11'h030);
      #3;
      checkOutput("l3_gnt_w0", wGntB, 64'h1);
      checkOutput("l3_addr_w0", bankAddrB, 64'h030);
      nextCycle();
      applyStimulus(2'b10, 2'b00, 11'h0, 11'h040, 1'b0, 1'b0, 11'h0);
      #3;
      checkOutput("l3_gnt_n1", nGntB, 64'h2);
      checkOutput("l3_addr_n1", bankAddrB, 64'h040);
      nextCycle();
      applyStimulus(2'b00, 2'b00, 11'h0, 11'h0, 1'b0, 1'b0, 11'h0);
      rdB = 64'h0000_0000_0000_D000;
      #3;
      checkOutput("l3_rv_n0", nRvalB, 64'h1);
      checkOutput("l3_rd_n0", nRdataB, 64'h0000_0000_0000_D000);
      checkOutput("l3_rv_w_off", wRvalB, 0);
      nextCycle();
      rdB = 64'h0000_0000_0000_D001;
      #3;
      checkOutput("l3_rv_w0", wRvalB, 64'h1);
      checkOutput("l3_rd_w0", wRdataB, 64'h0000_0000_0000_D001);
      checkOutput("l3_rv_n_off", nRvalB, 0);
      nextCycle();
      rdB = 64'h0000_0000_0000_D002;
      #3;
      checkOutput("l3_rv_n1", nRvalB, 64'h2);
      checkOutput("l3_rd_n1", nRdataB, 64'h0000_0000_0000_D002);
      nextCycle();
      #3;
      checkOutput("l3_done_n", nRvalB, 0);
      checkOutput("l3_done_w", wRvalB, 0);

      // reset while two reads are in flight in the latency-3 instance
      doReset();
      nextCycle();
      applyStimulus(2'b01, 2'b00, 11'h050, 11'h0, 1'b0, 1'b0, 11'h0);
      nextCycle();
      applyStimulus(2'b01, 2'b00, 11'h051, 11'h0, 1'b0, 1'b0, 11'h0);
      #3;
      checkOutput("mr_gnt", nGntB, 64'h1);
      nextCycle();
      applyStimulus(2'b00, 2'b00, 11'h0, 11'h0, 1'b0, 1'b0, 11'h0);
      rst = 1'b1;
      #3;
      checkOutput("mr_rv_c2", nRvalB, 0);
      nextCycle();
      rst = 1'b0;
      #3;
      checkOutput("mr_rv_c3", nRvalB, 0);
      nextCycle();
      #3;
      checkOutput("mr_rv_c4", nRvalB, 0);
      nextCycle();
      applyStimulus(2'b11, 2'b00, 11'h060, 11'h061, 1'b0, 1'b0, 11'h0);
      #3;
      checkOutput("mr_first_gntB", nGntB, 64'h1);
      checkOutput("mr_first_gntA", nGntA, 64'h1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
